song_select_ctrl: RTL

//  Parametrised song-selection controller for LEARN/PLAY modes. Debounces the five

---
 rtl/song_select_ctrl_pkg.sv | 29 ++
 rtl/song_select_ctrl_key_debounce.sv | 69 ++++++
 rtl/song_select_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/song_select_ctrl_pkg.sv
// Shared definitions for the song-selection controller: top-level mode codes,
// key bit positions, selection FSM states and the wrap-around step helper.
// The mode codes mirror the LEARN/PLAY/FREE/UART encodings of the top level.
package song_select_ctrl_pkg;

  localparam logic [1:0] FREE_MODE  = 2'd0;
  localparam logic [1:0] LEARN_MODE = 2'd1;
  localparam logic [1:0] PLAY_MODE  = 2'd2;
  localparam logic [1:0] UART_MODE  = 2'd3;

  localparam int KEY_CANCEL  = 0;
  localparam int KEY_DOWN    = 1;
  localparam int KEY_CONFIRM = 2;
  localparam int KEY_UP      = 4;

  typedef enum logic {
    SEL_BROWSE = 1'b0,
    SEL_LOCKED = 1'b1
  } sel_state_e;

  // One cursor step with wrap-around over n entries (n need not be a power of 2).
  function automatic int unsigned wrap_step(input int unsigned cur,
                                            input int unsigned n,
                                            input logic        up);
    if (up) return (cur >= n - 1) ? 0 : cur + 1;
    else    return (cur == 0) ? n - 1 : cur - 1;
  endfunction

endpackage

// File: rtl/song_select_ctrl_key_debounce.sv
// key_debounce: 2-flop synchroniser, consecutive-sample debouncer and rising-edge
// detector for one key. 'clr' empties the debouncer and disarms the edge detector,
// so a key already held when 'clr' drops must be released before it can produce
// another 'rise'.
module key_debounce #(
  parameter int unsigned DEB_CYCLES = 2_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic raw,
  output logic level,
  output logic rise
);

  // Counter only has to reach DEB_CYCLES-1; it is cleared on acceptance, never wraps.
  localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic             level_q;
  logic             level_d1_q;
  logic             armed_q;
  logic             samp;

  assign samp = sync_q[1];

  // Synchroniser keeps tracking the pin during clr so re-entry sees the true key level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '0;
    else      sync_q <= {sync_q[0], raw};
  end

  // Accept a new level after DEB_CYCLES consecutive samples that differ from the current one
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else if (clr) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else if (samp == level_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
      level_q <= samp;
      cnt_q   <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Edge detector; armed only once the key has been seen released after a clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level_d1_q <= 1'b0;
      armed_q    <= 1'b0;
    end else if (clr) begin
      level_d1_q <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      level_d1_q <= level_q;
      if (!level_q && !samp) armed_q <= 1'b1;
    end
  end

  assign level = level_q;
  assign rise  = level_q & ~level_d1_q & armed_q;

endmodule

// File: rtl/song_select_ctrl.sv
// song_select_ctrl: debounced up/down browsing over NUM_SONGS entries with wrap,
// confirm-to-lock and cancel-to-unlock. Only active in LEARN and PLAY modes; any
// other mode returns everything to its reset values on the next clock.
// Optional feature macro: SONG_AUTOREPEAT_EN (hold-to-repeat for up/down in BROWSE).
module song_select_ctrl
  import song_select_ctrl_pkg::*;
#(
  parameter  int unsigned NUM_SONGS     = 4,
  parameter  int unsigned DEB_CYCLES    = 2_000_000,
  parameter  int unsigned REPEAT_DELAY  = 50_000_000,
  parameter  int unsigned REPEAT_PERIOD = 20_000_000,
  localparam int unsigned SEL_W         = $clog2(NUM_SONGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       state,
  input  logic [4:0]       btn,
  output logic [SEL_W-1:0] cursor,
  output logic [SEL_W-1:0] song_sel,
  output logic             song_valid,
  output logic             sel_pulse,
  output sel_state_e       dbg_state
);

  logic mode_en;
  logic deb_clr;
  logic up_lvl, dn_lvl, cf_lvl, cn_lvl;
  logic up_rise, dn_rise, cf_rise, cn_rise;
  logic up_ev, dn_ev;

  sel_state_e       fsm_q, fsm_d;
  logic [SEL_W-1:0] cursor_q, cursor_d;
  logic [SEL_W-1:0] song_sel_q, song_sel_d;
  logic             valid_q, valid_d;
  logic             pulse_q, pulse_d;

  logic unused_btn;
  assign unused_btn = btn[3];

  // Block is enabled only in LEARN/PLAY; otherwise debouncers are held clear
  assign mode_en = (state == LEARN_MODE) || (state == PLAY_MODE);
  assign deb_clr = ~mode_en;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
    .clk(clk), .rst(rst), .clr(deb_clr), .raw(btn[KEY_UP]), .level(up_lvl), .rise(up_rise)
  );
  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dn (
    .clk(clk), .rst(rst), .clr(deb_clr), .raw(btn[KEY_DOWN]), .level(dn_lvl), .rise(dn_rise)
  );
  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_cf (
    .clk(clk), .rst(rst), .clr(deb_clr), .raw(btn[KEY_CONFIRM]), .level(cf_lvl), .rise(cf_rise)
  );
  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_cn (
    .clk(clk), .rst(rst), .clr(deb_clr), .raw(btn[KEY_CANCEL]), .level(cn_lvl), .rise(cn_rise)
  );

`ifdef SONG_AUTOREPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

  logic [REP_W-1:0] rep_cnt_q;
  logic             rep_run_q;
  logic             rep_first_q;
  logic             rep_hold;
  logic             rep_tick;
  logic             unused_levels;

  assign unused_levels = cf_lvl ^ cn_lvl;

  // Repeat runs only while exactly one of up/down is held in BROWSE after a real press.
  // rep_cnt equals the number of cycles since the press (or since the last repeat step).
  assign rep_hold = mode_en && (fsm_q == SEL_BROWSE) && (up_lvl ^ dn_lvl);
  assign rep_tick = rep_run_q && rep_hold &&
                    (rep_cnt_q == (rep_first_q ? REP_W'(REPEAT_DELAY) : REP_W'(REPEAT_PERIOD)));

  // Repeat counter: starts at the press, first step after REPEAT_DELAY, then every REPEAT_PERIOD
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rep_cnt_q   <= '0;
      rep_run_q   <= 1'b0;
      rep_first_q <= 1'b1;
    end else if (!rep_hold) begin
      rep_cnt_q   <= '0;
      rep_run_q   <= 1'b0;
      rep_first_q <= 1'b1;
    end else if (!rep_run_q) begin
      if (up_rise || dn_rise) begin
        rep_cnt_q   <= REP_W'(1);
        rep_run_q   <= 1'b1;
        rep_first_q <= 1'b1;
      end
    end else if (rep_tick) begin
      rep_cnt_q   <= REP_W'(1);
      rep_first_q <= 1'b0;
    end else if (rep_cnt_q != REP_W'(REP_MAX)) begin
      rep_cnt_q <= rep_cnt_q + 1'b1;
    end
  end

  assign up_ev = up_rise | (rep_tick & up_lvl);
  assign dn_ev = dn_rise | (rep_tick & dn_lvl);
`else
  logic unused_levels;
  assign unused_levels = up_lvl ^ dn_lvl ^ cf_lvl ^ cn_lvl;
  assign up_ev = up_rise;
  assign dn_ev = dn_rise;
`endif

  // FSM, cursor, latched selection and strobe registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q      <= SEL_BROWSE;
      cursor_q   <= '0;
      song_sel_q <= '0;
      valid_q    <= 1'b0;
      pulse_q    <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      cursor_q   <= cursor_d;
      song_sel_q <= song_sel_d;
      valid_q    <= valid_d;
      pulse_q    <= pulse_d;
    end
  end

  // Next state: confirm beats a move, up+down cancel out, cancel beats confirm when locked
  always_comb begin
    fsm_d      = fsm_q;
    cursor_d   = cursor_q;
    song_sel_d = song_sel_q;
    valid_d    = valid_q;
    pulse_d    = 1'b0;
    if (!mode_en) begin
      fsm_d      = SEL_BROWSE;
      cursor_d   = '0;
      song_sel_d = '0;
      valid_d    = 1'b0;
    end else begin
      case (fsm_q)
        SEL_BROWSE: begin
          if (cf_rise) begin
            song_sel_d = cursor_q;
            valid_d    = 1'b1;
            pulse_d    = 1'b1;
            fsm_d      = SEL_LOCKED;
          end else if (up_ev ^ dn_ev) begin
            cursor_d = SEL_W'(wrap_step(32'(cursor_q), NUM_SONGS, up_ev));
          end
        end
        SEL_LOCKED: begin
          if (cn_rise) begin
            valid_d = 1'b0;
            fsm_d   = SEL_BROWSE;
          end
        end
        default: fsm_d = SEL_BROWSE;
      endcase
    end
  end

  assign cursor     = cursor_q;
  assign song_sel   = song_sel_q;
  assign song_valid = valid_q;
  assign sel_pulse  = pulse_q;
  assign dbg_state  = fsm_q;

endmodule
